// File: rtl/mmio_responder.sv
// mmio_responder: four-word MMIO window on the CPU data-memory bus.
//   offset 0 TXDATA : write pushes into the TX FIFO, read returns 0
//   offset 1 STATUS : {tx_count[7:0], 4'b0, overflow, rx_valid, tx_empty, tx_full}
//                     write with data[3]=1 clears overflow
//   offset 2 RXDATA : read returns the holding register, popping it once per access
//   offset 3 CYCLE  : free-running counter, built only when MMIO_CYCLE_COUNTER_EN
//                     is defined; otherwise reads 0 and ignores writes
// q is registered (same latency as Memory) and is zero outside the window so the
// top level can OR it with Memory's q.
module mmio_responder #(
  parameter logic [15:0] BASE_ADDR  = 16'hFFF0,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] data,
  input  logic        wren,
  output logic [15:0] q,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Bus decode
  logic       hit;
  logic [1:0] offset;

  // TX FIFO state
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] tx_count;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_wr;
  logic          tx_push;
  logic          tx_pop;
  logic          ovf_event;
  logic          overflow;
  logic          ovf_clear;

  // RX holding register state
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_sel;
  logic        rx_hit_prev;
  logic        rx_pop;
  logic        rx_capture;

  // Read path
  logic [15:0] cycle_rd;
  logic [15:0] status;
  logic [15:0] rdata;

  assign hit    = (address[15:2] == BASE_ADDR[15:2]);
  assign offset = address[1:0];

  assign tx_full   = (tx_count == CW'(FIFO_DEPTH));
  assign tx_empty  = (tx_count == {CW{1'b0}});
  assign tx_pop    = !tx_empty && out_ready;
  assign tx_wr     = hit && (offset == 2'd0) && wren;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign tx_push   = tx_wr && (!tx_full || tx_pop);
  assign ovf_event = tx_wr && tx_full && !tx_pop;
  assign ovf_clear = hit && (offset == 2'd1) && wren && data[3];

  assign out_valid = !tx_empty;
  assign out_data  = tx_empty ? 16'h0000 : fifo_mem[rd_ptr];

  // Only loads pop RXDATA; the registered previous-hit flag makes a held
  // address pop exactly once.
  assign rx_sel     = hit && (offset == 2'd2) && !wren;
  assign rx_pop     = rx_sel && !rx_hit_prev;
  assign rx_capture = in_valid && !rx_valid;
  assign in_ready   = !rx_valid;

  assign status = {8'(tx_count), 4'b0000, overflow, rx_valid, tx_empty, tx_full};

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [15:0] cycle_count;

  // Free-running counter; a CYCLE store takes priority over the increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_count <= 16'h0000;
    end else if (hit && (offset == 2'd3) && wren) begin
      cycle_count <= data;
    end else begin
      cycle_count <= cycle_count + 16'h0001;
    end
  end

  assign cycle_rd = cycle_count;
`else
  assign cycle_rd = 16'h0000;
`endif

  // FIFO storage; contents need no reset because the empty flag masks them.
  always_ff @(posedge clock) begin
    if (tx_push) begin
      fifo_mem[wr_ptr] <= data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= {PW{1'b0}};
      rd_ptr   <= {PW{1'b0}};
      tx_count <= {CW{1'b0}};
    end else begin
      if (tx_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (tx_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow event beats a software clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_event) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

  // RX holding register; a capture is only possible while empty, so it never
  // coincides with a pop of valid data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_data     <= 16'h0000;
      rx_valid    <= 1'b0;
      rx_hit_prev <= 1'b0;
    end else begin
      rx_hit_prev <= rx_sel;
      if (rx_capture) begin
        rx_data  <= in_data;
        rx_valid <= 1'b1;
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
    end
  end

  // Read mux over pre-edge state, giving read-before-write behaviour.
  always_comb begin
    rdata = 16'h0000;
    if (hit) begin
      case (offset)
        2'd0:    rdata = 16'h0000;
        2'd1:    rdata = status;
        2'd2:    rdata = rx_data;
        2'd3:    rdata = cycle_rd;
        default: rdata = 16'h0000;
      endcase
    end else begin
      rdata = 16'h0000;
    end
  end

  // Registered load data, one cycle of latency like Memory.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= 16'h0000;
    end else begin
      q <= rdata;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder. Inputs change 1 ns after a
// rising edge and outputs are sampled at that same point.
module tb_mmio_responder;

  logic        clock;
  logic        reset;
  logic [15:0] address;
  logic [15:0] data;
  logic        wren;
  logic [15:0] q;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;

  int checks = 0;
  int errors = 0;

  mmio_responder #(.BASE_ADDR(16'hFFF0), .FIFO_DEPTH(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .data     (data),
    .wren     (wren),
    .q        (q),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; address = 16'h0000; data = 16'h0000; wren = 1'b0;
    out_ready = 1'b0; in_data = 16'h0000; in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    checks++;
    if ({q, out_valid, out_data, in_ready} !== {16'h0000, 1'b0, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: got q=%h ov=%b od=%h ir=%b, expected q=0000 ov=0 od=0000 ir=1",
               q, out_valid, out_data, in_ready);
    end
    address = 16'hFFF1;
    step();
    checks++;
    if (q !== 16'h0002) begin
      errors++;
      $display("FAIL reset_status: got %h expected 0002", q);
    end
  endtask

  task automatic test_tx_overflow();
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      address = 16'hFFF0; wren = 1'b1; data = 16'(i);
      step();
      if (i == 1) begin
        checks++;
        if ({out_valid, out_data} !== {1'b1, 16'h0001}) begin
          errors++;
          $display("FAIL first_push_visible: got ov=%b od=%h expected ov=1 od=0001", out_valid, out_data);
        end
      end
    end
    address = 16'hFFF1; wren = 1'b0;
    step();
    checks++;
    if (q !== 16'h0809) begin
      errors++;
      $display("FAIL status_full_overflow: got %h expected 0809", q);
    end
    data = 16'h0008; wren = 1'b1;
    step();
    wren = 1'b0;
    step();
    checks++;
    if (q !== 16'h0801) begin
      errors++;
      $display("FAIL overflow_clear: got %h expected 0801", q);
    end
    address = 16'h0010; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if ({out_valid, out_data} !== {1'b1, 16'(k)}) begin
        errors++;
        $display("FAIL drain_%0d: got ov=%b od=%h expected ov=1 od=%h", k, out_valid, out_data, 16'(k));
      end
      step();
    end
    checks++;
    if ({out_valid, out_data} !== {1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL drain_empty: got ov=%b od=%h expected ov=0 od=0000", out_valid, out_data);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      address = 16'hFFF0; wren = 1'b1; data = 16'h0010 + 16'(i);
      step();
    end
    wren = 1'b0;
    step();
    checks++;
    if ({q, out_data} !== {16'h0000, 16'h0010}) begin
      errors++;
      $display("FAIL txdata_read: got q=%h od=%h expected q=0000 od=0010", q, out_data);
    end
    wren = 1'b1; data = 16'h0018; out_ready = 1'b1;
    step();
    address = 16'hFFF1; wren = 1'b0; out_ready = 1'b0;
    step();
    checks++;
    if (q !== 16'h0801) begin
      errors++;
      $display("FAIL full_push_pop_status: got %h expected 0801", q);
    end
    address = 16'h0010; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({out_valid, out_data} !== {1'b1, 16'h0011 + 16'(k)}) begin
        errors++;
        $display("FAIL pp_drain_%0d: got ov=%b od=%h expected ov=1 od=%h",
                 k, out_valid, out_data, 16'h0011 + 16'(k));
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pp_drain_empty: got ov=%b expected 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_rx();
    address = 16'h0010; wren = 1'b0;
    in_data = 16'hBEEF; in_valid = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rx_capture: got in_ready=%b expected 0", in_ready);
    end
    address = 16'hFFF2; in_data = 16'hCAFE; in_valid = 1'b1;
    step();
    checks++;
    if ({q, in_ready} !== {16'hBEEF, 1'b1}) begin
      errors++;
      $display("FAIL rx_hold_1: got q=%h ir=%b expected q=BEEF ir=1", q, in_ready);
    end
    step();
    checks++;
    if ({q, in_ready} !== {16'hBEEF, 1'b0}) begin
      errors++;
      $display("FAIL rx_hold_2: got q=%h ir=%b expected q=BEEF ir=0", q, in_ready);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if ({q, in_ready} !== {16'hCAFE, 1'b0}) begin
      errors++;
      $display("FAIL rx_hold_3: got q=%h ir=%b expected q=CAFE ir=0", q, in_ready);
    end
    address = 16'h0010;
    step();
    address = 16'hFFF2;
    step();
    checks++;
    if ({q, in_ready} !== {16'hCAFE, 1'b1}) begin
      errors++;
      $display("FAIL rx_second_pop: got q=%h ir=%b expected q=CAFE ir=1", q, in_ready);
    end
    address = 16'h0010;
    step();
  endtask

  task automatic test_cycle();
    logic [15:0] exp_seq [3];
`ifdef MMIO_CYCLE_COUNTER_EN
    exp_seq[0] = 16'hFFFE; exp_seq[1] = 16'hFFFF; exp_seq[2] = 16'h0000;
`else
    exp_seq[0] = 16'h0000; exp_seq[1] = 16'h0000; exp_seq[2] = 16'h0000;
`endif
    address = 16'hFFF3; wren = 1'b1; data = 16'hFFFE;
    step();
    wren = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (q !== exp_seq[k]) begin
        errors++;
        $display("FAIL cycle_read_%0d: got %h expected %h", k, q, exp_seq[k]);
      end
    end
  endtask

  task automatic test_outside();
    address = 16'hFFF1; wren = 1'b0;
    step();
    checks++;
    if (q !== 16'h0002) begin
      errors++;
      $display("FAIL outside_pre_status: got %h expected 0002", q);
    end
    address = 16'h0010; wren = 1'b1; data = 16'h1234;
    step();
    checks++;
    if ({q, out_valid, in_ready} !== {16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL outside_write: got q=%h ov=%b ir=%b expected q=0000 ov=0 ir=1", q, out_valid, in_ready);
    end
    address = 16'hFFF1; wren = 1'b0;
    step();
    checks++;
    if (q !== 16'h0002) begin
      errors++;
      $display("FAIL outside_post_status: got %h expected 0002", q);
    end
  endtask

  initial begin
    test_reset();
    test_tx_overflow();
    test_full_push_pop();
    test_rx();
    test_cycle();
    test_outside();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
